if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 The block SHALL expose parameter RESET_PC, default 32'hBFC0_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL expose parameter FIFO_DEPTH, default 2, meaning the fetch buffer entries; only 2 is required to work.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 stall_i  in  1  ID not accepting; head entry held.
REQ-006 redirect_i  in  1  branch/jump/exception redirect request.
REQ-007 redirect_pc_i  in  32  redirect target.
REQ-008 imem_req_o  out  1  instruction memory request.
REQ-009 imem_addr_o  out  32  word-aligned request address.
REQ-010 imem_ack_i  in  1  request completed this cycle; may be asserted in the same cycle as the request is raised.
REQ-011 imem_rdata_i  in  32  instruction, valid when imem_ack_i=1.
REQ-012 valid_o  out  1  pc_o/inst_o hold a real instruction for ID.
REQ-013 pc_o  out  32  PC of the head instruction.
REQ-014 inst_o  out  32  head instruction; all zeros (NOP) when valid_o=0.

Function
REQ-015 The FSM SHALL have the states BOOT, RUN and DISCARD; reset enters BOOT, and BOOT goes to RUN unconditionally after one cycle with imem_req_o=0.
REQ-016 In RUN, imem_req_o SHALL be 1 exactly when buffer count<2, with imem_addr_o=fetch_pc; imem_req_o and imem_addr_o SHALL depend only on registered state.
REQ-017 Once raised, imem_req_o and imem_addr_o SHALL remain stable until a cycle with imem_ack_i=1; the memory handshake is never abandoned.
REQ-018 An imem_ack_i received in RUN with no redirect SHALL push {fetch_pc, imem_rdata_i} into the buffer and set fetch_pc to fetch_pc+4, mod 2^32, wrapping at 32'hFFFF_FFFC to 0.
REQ-019 imem_ack_i SHALL be ignored while imem_req_o=0.
REQ-020 valid_o SHALL equal (count!=0), and pc_o/inst_o SHALL present the head entry; the head is popped on any edge with valid_o=1 and stall_i=0.
REQ-021 A push and a pop in the same cycle SHALL leave count unchanged and keep FIFO order; the buffer SHALL never overflow or underflow.
REQ-022 With zero-wait memory and no stall, throughput SHALL be one instruction per cycle, and an instruction SHALL appear on valid_o the cycle after its ack.
REQ-023 redirect_i SHALL take priority over stall_i and over push; it flushes the buffer (count=0) and loads fetch_pc with {redirect_pc_i[31:2],2'b00}.
REQ-024 redirect_i SHALL take effect as follows, depending on the outstanding request:
- Request outstanding (imem_req_o=1, imem_ack_i=0): go to DISCARD.
- No request outstanding, or ack in the same cycle: stay in RUN, and drop the acked data.
REQ-025 In DISCARD, imem_req_o=1 and imem_addr_o SHALL be the held pre-redirect address; on ack the data is dropped and the FSM returns to RUN, requesting the new fetch_pc from the next cycle.
REQ-026 A further redirect_i while in DISCARD SHALL update fetch_pc and keep the FSM in DISCARD.
REQ-027 valid_o SHALL be 0 in the cycle after any redirect_i.

Reset
REQ-028 On rst=1 at a clock edge, the block SHALL reset as follows:
- state=BOOT, fetch_pc=RESET_PC, count=0.
- valid_o=0, pc_o=0, inst_o=0.
- imem_req_o=0, imem_addr_o=RESET_PC.
REQ-029 Reset mid-handshake SHALL abandon the outstanding request without waiting for ack, and any ack during or after reset before RUN SHALL be ignored.

Structure
REQ-030 The shared cpu package SHALL hold Inst_addr_t, Inst_t, the RESET_PC default, the Fetch_state_t enum (BOOT/RUN/DISCARD) and the Fetch_entry_t struct {pc, inst}.
REQ-031 The buffer SHALL be a sub-module fetch_fifo (2-entry, synchronous rst, push/pop/flush, count, head output); the FSM and PC logic SHALL stay in if_fetch.

Verification
REQ-032 The bench SHALL cover reset release with always-ack memory: imem_req_o=1 with address BFC00000 in cycle 2, then valid_o=1 with pc_o=BFC00000, BFC00004, ... on consecutive cycles.
REQ-033 The bench SHALL cover stall_i=1 for 5 cycles with zero-wait memory: count reaches 2, imem_req_o drops, and pc_o is held; after release, order is preserved with no gap and no duplicate.
REQ-034 The bench SHALL cover a 3-cycle ack latency with redirect_i to 0x80000100 in the wait's second cycle: imem_addr_o is held until ack, the data is dropped, the next request is 0x80000100, and the first valid pc_o is 0x80000100.
REQ-035 The bench SHALL cover redirect_pc_i=0x80000103 with ack in the same cycle: the acked word is discarded, and the next fetch is 0x80000100.
REQ-036 The bench SHALL cover a redirect to FFFFFFFC with always-ack memory: pc_o sequence FFFFFFFC then 00000000.
REQ-037 The bench SHALL cover rst asserted while imem_req_o=1 and awaiting ack: the next cycle shows imem_req_o=0, valid_o=0 and inst_o=0, and a late ack is ignored.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared CPU fetch types: address/instruction words, the fetch FSM
// states, the fetch buffer entry and small PC helpers.
package if_fetch_pkg;

    typedef logic [31:0] Inst_addr_t;
    typedef logic [31:0] Inst_t;

    localparam Inst_addr_t DEFAULT_RESET_PC = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RUN     = 2'd1,
        DISCARD = 2'd2
    } Fetch_state_t;

    typedef struct packed {
        Inst_addr_t pc;
        Inst_t      inst;
    } Fetch_entry_t;

    function automatic Inst_addr_t word_align(input Inst_addr_t a);
        return {a[31:2], 2'b00};
    endfunction

    // Wraps naturally from FFFF_FFFC to 0.
    function automatic Inst_addr_t next_pc(input Inst_addr_t a);
        return a + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Small fetch buffer between the memory handshake and ID.
// Ports: clk, rst (sync, high), push/din, pop, flush, head, count.
module fetch_fifo
    import if_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  Fetch_entry_t din,
    output Fetch_entry_t head,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    Fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            full;
    logic            empty;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full buffer is only legal when the head leaves now.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: PC sequencing, imem handshake, redirects.
// Ports: clk, rst, stall_i, redirect_i/redirect_pc_i, imem_* bus,
// valid_o/pc_o/inst_o head instruction towards ID.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter Inst_addr_t RESET_PC   = DEFAULT_RESET_PC,
    parameter int         FIFO_DEPTH = 2
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    Fetch_state_t    state;
    Inst_addr_t      fetch_pc;
    Inst_addr_t      hold_addr;
    Fetch_entry_t    head;
    Fetch_entry_t    push_entry;
    logic [CW-1:0]   count;
    logic            full;
    logic            ack;
    logic            push;
    logic            pop;

    assign full = (count == CW'(FIFO_DEPTH));

    // Request lines come from registers only; in DISCARD the old
    // handshake is completed on the address captured at redirect.
    assign imem_req_o  = (state == DISCARD) || ((state == RUN) && !full);
    assign imem_addr_o = (state == DISCARD) ? hold_addr : fetch_pc;

    assign ack  = imem_req_o && imem_ack_i;
    assign push = (state == RUN) && ack && !redirect_i;
    assign pop  = valid_o && !stall_i;

    assign push_entry = '{pc: fetch_pc, inst: imem_rdata_i};

    assign valid_o = (count != '0);
    assign pc_o    = valid_o ? head.pc   : '0;
    assign inst_o  = valid_o ? head.inst : '0;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_i),
        .din   (push_entry),
        .head  (head),
        .count (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BOOT;
            fetch_pc  <= RESET_PC;
            hold_addr <= RESET_PC;
        end else begin
            unique case (state)
                BOOT: begin
                    state <= RUN;
                    if (redirect_i) fetch_pc <= word_align(redirect_pc_i);
                end
                RUN: begin
                    if (redirect_i) begin
                        fetch_pc <= word_align(redirect_pc_i);
                        if (imem_req_o && !imem_ack_i) begin
                            state     <= DISCARD;
                            hold_addr <= fetch_pc;
                        end
                    end else if (ack) begin
                        fetch_pc <= next_pc(fetch_pc);
                    end
                end
                DISCARD: begin
                    if (redirect_i) fetch_pc <= word_align(redirect_pc_i);
                    // The stale handshake is done; its data is dropped.
                    if (imem_ack_i) state <= RUN;
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: queue-based fetch model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] RPC = 32'hBFC0_0000;

    always #5 clk = ~clk;

    if_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .valid_o       (valid_o),
        .pc_o          (pc_o),
        .inst_o        (inst_o)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // Memory responder: ack in the mem_lat-th cycle of a request.
    int mem_lat  = 1;
    bit mem_auto = 1'b1;
    bit force_ack = 1'b0;
    int wait_cnt = 0;

    assign imem_ack_i = mem_auto ?
        (imem_req_o && (wait_cnt >= mem_lat - 1)) : force_ack;
    assign imem_rdata_i = word(imem_addr_o);

    always @(posedge clk) begin
        if (rst || !imem_req_o || imem_ack_i) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of delivered instructions plus the
    // next address to fetch and an optional stale request to finish.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        q[$];
    bit          m_boot;
    bit          m_disc;
    bit          model_en = 1'b0;
    logic [31:0] m_pc;
    logic [31:0] m_hold;

    function automatic bit m_req();
        return !m_boot && (m_disc || q.size() < 2);
    endfunction

    function automatic logic [31:0] m_addr();
        return m_disc ? m_hold : m_pc;
    endfunction

    initial begin
        bit req;
        bit ack;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_boot = 1'b1;
                m_disc = 1'b0;
                m_pc = RPC;
                m_hold = RPC;
                q.delete();
                model_en = 1'b1;
            end else if (model_en && m_boot) begin
                m_boot = 1'b0;
                if (redirect_i) m_pc = {redirect_pc_i[31:2], 2'b00};
            end else if (model_en) begin
                req = m_req();
                ack = imem_ack_i && req;
                if (redirect_i) begin
                    if (!m_disc && req && !ack) begin
                        m_disc = 1'b1;
                        m_hold = m_pc;
                    end else if (m_disc && ack) begin
                        m_disc = 1'b0;
                    end
                    q.delete();
                    m_pc = {redirect_pc_i[31:2], 2'b00};
                end else begin
                    if (q.size() > 0 && !stall_i) void'(q.pop_front());
                    if (ack) begin
                        if (m_disc) m_disc = 1'b0;
                        else begin
                            q.push_back('{m_pc, word(m_pc)});
                            m_pc = m_pc + 32'd4;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_en) begin
            check("model_req", {31'd0, imem_req_o}, {31'd0, m_req()});
            if (m_req())
                check("model_addr", imem_addr_o, m_addr());
            check("model_valid", {31'd0, valid_o},
                  {31'd0, q.size() != 0});
            check("model_pc", pc_o, q.size() != 0 ? q[0].pc : 32'd0);
            check("model_inst", inst_o,
                  q.size() != 0 ? q[0].inst : 32'd0);
        end
    end

    task automatic nc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nc(2);
        check("rst_req", {31'd0, imem_req_o}, 32'd0);
        check("rst_addr", imem_addr_o, RPC);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_pc", pc_o, 32'd0);
        check("rst_inst", inst_o, 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = '0;

        // Reset release, zero-wait memory.
        mem_lat = 1;
        do_reset();
        nc();
        check("boot_req", {31'd0, imem_req_o}, 32'd1);
        check("boot_addr", imem_addr_o, 32'hBFC0_0000);
        nc();
        check("s1_valid", {31'd0, valid_o}, 32'd1);
        check("s1_pc0", pc_o, 32'hBFC0_0000);
        check("s1_inst0", inst_o, 32'hBFC0_0000 ^ 32'h5A5A_0F0F);
        nc();
        check("s1_pc1", pc_o, 32'hBFC0_0004);
        nc();
        check("s1_pc2", pc_o, 32'hBFC0_0008);

        // Stall for 5 cycles: buffer fills, request drops, head held.
        stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            nc();
            check("stall_req", {31'd0, imem_req_o}, 32'd0);
            check("stall_pc", pc_o, 32'hBFC0_0008);
        end
        stall_i = 1'b0;
        nc();
        check("rel_pc0", pc_o, 32'hBFC0_000C);
        nc();
        check("rel_pc1", pc_o, 32'hBFC0_0010);
        nc();
        check("rel_pc2", pc_o, 32'hBFC0_0014);

        // 3-cycle latency, redirect in the second wait cycle.
        mem_lat = 3;
        do_reset();
        nc();
        check("lat_addr_a", imem_addr_o, 32'hBFC0_0000);
        nc();
        check("lat_addr_b", imem_addr_o, 32'hBFC0_0000);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h8000_0100;
        nc();
        redirect_i = 1'b0;
        check("lat_hold", imem_addr_o, 32'hBFC0_0000);
        check("lat_hold_req", {31'd0, imem_req_o}, 32'd1);
        check("lat_v0", {31'd0, valid_o}, 32'd0);
        nc();
        check("lat_new_addr", imem_addr_o, 32'h8000_0100);
        check("lat_v1", {31'd0, valid_o}, 32'd0);
        nc(2);
        check("lat_v2", {31'd0, valid_o}, 32'd0);
        nc();
        check("lat_first_v", {31'd0, valid_o}, 32'd1);
        check("lat_first_pc", pc_o, 32'h8000_0100);

        // Redirect with ack in the same cycle, unaligned target.
        mem_lat = 1;
        do_reset();
        nc();
        check("same_ack", {31'd0, imem_ack_i}, 32'd1);
        redirect_i = 1'b1;
        redirect_pc_i = 32'h8000_0103;
        nc();
        redirect_i = 1'b0;
        check("same_valid", {31'd0, valid_o}, 32'd0);
        check("same_addr", imem_addr_o, 32'h8000_0100);
        nc();
        check("same_pc", pc_o, 32'h8000_0100);

        // Redirect to the top of the address space, wrap to 0.
        nc();
        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        nc();
        redirect_i = 1'b0;
        check("wrap_valid", {31'd0, valid_o}, 32'd0);
        nc();
        check("wrap_pc0", pc_o, 32'hFFFF_FFFC);
        nc();
        check("wrap_pc1", pc_o, 32'h0000_0000);
        nc();
        check("wrap_pc2", pc_o, 32'h0000_0004);

        // Reset while a request waits for ack; late ack ignored.
        mem_lat = 4;
        do_reset();
        nc();
        check("mid_req", {31'd0, imem_req_o}, 32'd1);
        rst = 1'b1;
        nc();
        check("mid_req0", {31'd0, imem_req_o}, 32'd0);
        check("mid_valid0", {31'd0, valid_o}, 32'd0);
        check("mid_inst0", inst_o, 32'd0);
        mem_auto = 1'b0;
        force_ack = 1'b1;
        nc();
        rst = 1'b0;
        nc();
        force_ack = 1'b0;
        mem_auto = 1'b1;
        mem_lat = 1;
        check("late_valid", {31'd0, valid_o}, 32'd0);
        check("late_addr", imem_addr_o, 32'hBFC0_0000);
        nc();
        check("late_pc", pc_o, 32'hBFC0_0000);
        check("late_inst", inst_o, 32'hBFC0_0000 ^ 32'h5A5A_0F0F);
        nc(3);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
